// File: rtl/posit_frac_product_normalizer.sv
// ---------------------------------------------------------------------------
// posit_frac_product_normalizer
//
// Purpose:
//   Sits directly after the 7x7 unsigned fraction multiplier in the posit FMA
//   datapath. It takes the 14-bit significand product (two 1.6 operands, so the
//   product is 2.12). It then normalises the product to 1.x, adjusts the
//   combined scale, and rounds to FW fraction bits with round-to-nearest-even.
//   It also flags zero and inexact results. The block is a two-stage
//   valid/ready pipeline with backpressure and a synchronous flush. Its output
//   feeds the posit regime/exponent encoder.
//
//   Stage 1 (normalise): chooses the fraction window from the product MSB,
//                        splits it into F / guard / sticky, and adds the
//                        normalisation increment to the scale.
//   Stage 2 (round)    : applies the RNE increment and propagates a fraction
//                        carry into the scale.
//
// Parameters:
//   FW  output fraction width, hidden bit dropped (legal 1..11)
//   SW  signed scale width (two's complement)
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_ni         asynchronous active-low reset
//   flush_i        synchronous clear of both pipeline stages
//   in_valid_i     input product valid
//   in_ready_o     block can accept an input this cycle
//   in_prod_i      unsigned product A*B, 2.12 fixed point
//   in_scale_i     sum of the operand scales, signed
//   in_sign_i      result sign (XOR of the operand signs)
//   out_valid_o    output result valid
//   out_ready_i    downstream accepts the result
//   out_frac_o     rounded normalised fraction (hidden bit removed)
//   out_scale_o    adjusted scale, signed
//   out_sign_o     sign, passed through
//   out_zero_o     product was zero
//   out_inexact_o  guard or sticky was nonzero before rounding
// ---------------------------------------------------------------------------
module posit_frac_product_normalizer #(
    parameter int FW = 6,
    parameter int SW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [13:0]          in_prod_i,
    input  logic signed [SW-1:0] in_scale_i,
    input  logic                 in_sign_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [FW-1:0]        out_frac_o,
    output logic signed [SW-1:0] out_scale_o,
    output logic                 out_sign_o,
    output logic                 out_zero_o,
    output logic                 out_inexact_o
);

    // Increment a signed scale by 0 or 1. The sum is formed one bit wider,
    // and the result clamps at the largest positive value. The scale only
    // ever grows here, so only positive overflow can happen.
    function automatic logic signed [SW-1:0] satInc(input logic signed [SW-1:0] a,
                                                    input logic inc);
        logic [SW:0] wide;
        wide = {a[SW-1], a} + {{SW{1'b0}}, inc};
        if (wide[SW] != wide[SW-1]) begin
            satInc = {1'b0, {(SW-1){1'b1}}};
        end else begin
            satInc = wide[SW-1:0];
        end
    endfunction

    // Pipeline state
    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;

    logic [FW-1:0]        f1_q, f1_d;
    logic                 g1_q, g1_d;
    logic                 s1_q, s1_d;
    logic                 zero1_q, zero1_d;
    logic                 sign1_q, sign1_d;
    logic signed [SW-1:0] scale1_q, scale1_d;

    logic [FW-1:0]        frac2_q, frac2_d;
    logic signed [SW-1:0] scale2_q, scale2_d;
    logic                 sign2_q, sign2_d;
    logic                 zero2_q, zero2_d;
    logic                 inexact2_q, inexact2_d;

    logic                 load1;
    logic                 load2;
    logic                 adv2;

    // Handshake. Stage 2 can take a new token when it is empty or its token
    // leaves this cycle. Stage 1 can accept when it is empty or its token
    // moves on. This is equivalent to !v1 | !v2 | out_ready and never
    // depends on in_valid.
    always_comb begin
        adv2       = !v2_q || out_ready_i;
        in_ready_o = !v1_q || adv2;
        load1      = in_valid_i && in_ready_o;
        load2      = adv2 && v1_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        if (flush_i) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else begin
            if (in_ready_o) begin
                v1_d = in_valid_i;
            end
            if (adv2) begin
                v2_d = v1_q;
            end
        end
    end

    // Stage 1 normalisation. A set product MSB means the value lies in
    // [2,4): the window starts one bit lower and the scale gains one.
    // Otherwise the product is already 1.x and is shifted so that the
    // hidden bit leaves the window. Illegal products (top two bits clear
    // but nonzero) take the 1.x path unchecked.
    always_comb begin
        logic        norm;
        logic [12:0] field;
        norm     = in_prod_i[13];
        field    = norm ? in_prod_i[12:0] : {in_prod_i[11:0], 1'b0};
        f1_d     = field[12 -: FW];
        g1_d     = field[12-FW];
        s1_d     = |field[11-FW:0];
        zero1_d  = (in_prod_i == 14'd0);
        sign1_d  = in_sign_i;
        scale1_d = satInc(in_scale_i, norm);
    end

    // Stage 2 rounding. Round to nearest even: round up when the guard bit
    // is set and either the sticky bit or the LSB is set. An all-ones F
    // wraps to zero, and the scale absorbs the carry. A zero product skips
    // rounding entirely and keeps its scale.
    always_comb begin
        logic          inc;
        logic [FW:0]   sum;
        inc        = g1_q & (s1_q | f1_q[0]);
        sum        = {1'b0, f1_q} + {{FW{1'b0}}, inc};
        sign2_d    = sign1_q;
        zero2_d    = zero1_q;
        frac2_d    = sum[FW-1:0];
        scale2_d   = satInc(scale1_q, sum[FW]);
        inexact2_d = g1_q | s1_q;
        if (zero1_q) begin
            frac2_d    = '0;
            scale2_d   = scale1_q;
            inexact2_d = 1'b0;
        end
    end

    // Valid bits. Reset and flush clear them so that in-flight tokens
    // vanish without any partial output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // Stage 1 data. This register loads only on an accepted transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f1_q     <= '0;
            g1_q     <= 1'b0;
            s1_q     <= 1'b0;
            zero1_q  <= 1'b0;
            sign1_q  <= 1'b0;
            scale1_q <= '0;
        end else if (load1) begin
            f1_q     <= f1_d;
            g1_q     <= g1_d;
            s1_q     <= s1_d;
            zero1_q  <= zero1_d;
            sign1_q  <= sign1_d;
            scale1_q <= scale1_d;
        end
    end

    // Stage 2 data. It holds steady while the output is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frac2_q    <= '0;
            scale2_q   <= '0;
            sign2_q    <= 1'b0;
            zero2_q    <= 1'b0;
            inexact2_q <= 1'b0;
        end else if (load2) begin
            frac2_q    <= frac2_d;
            scale2_q   <= scale2_d;
            sign2_q    <= sign2_d;
            zero2_q    <= zero2_d;
            inexact2_q <= inexact2_d;
        end
    end

    assign out_valid_o   = v2_q;
    assign out_frac_o    = frac2_q;
    assign out_scale_o   = scale2_q;
    assign out_sign_o    = sign2_q;
    assign out_zero_o    = zero2_q;
    assign out_inexact_o = inexact2_q;

endmodule
